// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states
// and the fixed divide-by-zero quotient.
package muldiv_pkg;

    localparam int MD_W = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam logic [MD_W-1:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// remainder, subtract the divisor if it fits, shift the quotient bit in.
module muldiv_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quo_out
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    logic            fits;

    assign shifted = {rem_in, quo_in[DATA_W-1]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = (shifted >= {1'b0, divisor});
    assign rem_out = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quo_out = {quo_in[DATA_W-2:0], fits};

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (divide unchanged).
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ITER_CNT_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [ITER_CNT_W-1:0]   cnt_q;
    logic [2*DATA_W-1:0]     acc_q;
    logic [DATA_W-1:0]       mag_b_q, raw_a_q, hi_q, lo_q;
    logic                    is_div_q, div0_q, neg_q_q, neg_r_q, done_q;

    logic                    sgn_op, start_arith;
    logic [DATA_W-1:0]       mag_a, mag_b;
    logic [DATA_W:0]         mul_sum;
    logic [2*DATA_W-1:0]     mul_next;
    logic [DATA_W-1:0]       div_rem, div_quo;
    logic [DATA_W-1:0]       fix_hi, fix_lo;
    logic [2*DATA_W-1:0]     prod_signed;

    assign sgn_op      = ~i_op[0];
    assign start_arith = i_start && !i_flush && !i_op[2];
    assign mag_a = (sgn_op && i_rs_data[DATA_W-1]) ? -i_rs_data : i_rs_data;
    assign mag_b = (sgn_op && i_rt_data[DATA_W-1]) ? -i_rt_data : i_rt_data;

    // Multiply: low half of acc holds the remaining multiplier bits, high half the partial sum.
    assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
    assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

    muldiv_div_step #(.DATA_W(DATA_W)) u_div_step (
        .rem_in  (acc_q[2*DATA_W-1:DATA_W]),
        .quo_in  (acc_q[DATA_W-1:0]),
        .divisor (mag_b_q),
        .rem_out (div_rem),
        .quo_out (div_quo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_arith) state_d = (FAST_MUL && !i_op[1]) ? ST_FIX : ST_CALC;
            ST_CALC: begin
                if (i_flush) state_d = ST_IDLE;
                else if (cnt_q == ITER_CNT_W'(DATA_W-1)) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prod_signed = neg_q_q ? -acc_q : acc_q;
        fix_hi      = prod_signed[2*DATA_W-1:DATA_W];
        fix_lo      = prod_signed[DATA_W-1:0];
        if (is_div_q) begin
            if (div0_q) begin
                fix_hi = raw_a_q;
                fix_lo = DIV0_LO;
            end else begin
                fix_hi = neg_r_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
                fix_lo = neg_q_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_b_q  <= '0;
            raw_a_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_arith) begin
                        // Both iterative paths start from {0, |A|} with |B| held aside.
                        acc_q    <= {{DATA_W{1'b0}}, mag_a};
`ifdef MULDIV_FAST_MUL_EN
                        if (!i_op[1]) acc_q <= mag_a * mag_b;
`endif
                        mag_b_q  <= mag_b;
                        raw_a_q  <= i_rs_data;
                        is_div_q <= i_op[1];
                        div0_q   <= (i_rt_data == '0);
                        neg_q_q  <= sgn_op && (i_rs_data[DATA_W-1] ^ i_rt_data[DATA_W-1]);
                        neg_r_q  <= sgn_op && i_rs_data[DATA_W-1];
                        cnt_q    <= '0;
                    end else if (i_start && !i_flush && i_op == OP_MTHI) begin
                        hi_q   <= i_rs_data;
                        done_q <= 1'b1;
                    end else if (i_start && !i_flush && i_op == OP_MTLO) begin
                        lo_q   <= i_rs_data;
                        done_q <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (!i_flush) begin
                        acc_q <= is_div_q ? {div_rem, div_quo} : mul_next;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_FIX: begin
                    if (!i_flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_done = done_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int passes = 0;
    int total  = 0;
    int busy_cnt, done_cnt, busy_seen;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_BUSY = 1;
`else
    localparam int MUL_BUSY = 33;
`endif

    muldiv_unit dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_op      (op),
        .i_rs_data (rs),
        .i_rt_data (rt),
        .i_flush   (flush),
        .o_busy    (busy),
        .o_done    (done),
        .o_hi      (hi),
        .o_lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Issue one op and watch busy/done at every negedge for a bounded window.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int nbusy, output int ndone);
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0;
        nbusy = 0; ndone = 0;
        for (int i = 0; i < 45; i++) begin
            if (busy) nbusy++;
            if (done) ndone++;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);

        run_op(3'b000, 32'hFFFF_FFFE, 32'd3, busy_cnt, done_cnt);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("mult_busy_cycles", busy_cnt, MUL_BUSY);
        chk("mult_done_pulses", done_cnt, 1);

        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_cnt, done_cnt);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, busy_cnt, done_cnt);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        chk("div_busy_cycles", busy_cnt, 33);
        chk("div_done_pulses", done_cnt, 1);

        run_op(3'b011, 32'd7, 32'd0, busy_cnt, done_cnt);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd7);
        chk("divu0_busy_cycles", busy_cnt, 33);

        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, busy_cnt, done_cnt);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0);

        // MTHI then MTLO back to back
        busy_seen = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b100; rs = 32'h1234_5678;
        @(negedge clk);
        if (busy) busy_seen++;
        chk("mthi_hi", hi, 32'h1234_5678);
        chk("mthi_done", {31'b0, done}, 32'h1);
        op = 3'b101; rs = 32'h9ABC_DEF0;
        @(negedge clk);
        if (busy) busy_seen++;
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("mtlo_hi_kept", hi, 32'h1234_5678);
        @(negedge clk);
        if (busy) busy_seen++;
        chk("mt_done_clear", {31'b0, done}, 32'h0);
        chk("mt_busy_never", busy_seen, 0);

        // Reserved op is ignored
        @(negedge clk);
        start = 1'b1; op = 3'b110; rs = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        chk("rsvd_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        chk("rsvd_done", {31'b0, done}, 32'h0);
        chk("rsvd_hi", hi, 32'h1234_5678);

        // Flush mid-divide, with an ignored start while busy
        @(negedge clk); start = 1'b1; op = 3'b100; rs = 32'hAAAA_AAAA;
        @(negedge clk); op = 3'b101; rs = 32'h5555_5555;
        @(negedge clk); op = 3'b010; rs = 32'd100; rt = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'b100; rs = 32'h0BAD_0BAD;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) done_cnt++;
            @(negedge clk);
        end
        chk("flush_no_done", done_cnt, 0);
        chk("flush_hi", hi, 32'hAAAA_AAAA);
        chk("flush_lo", lo, 32'h5555_5555);

        // Flush together with start in IDLE drops the start
        start = 1'b1; flush = 1'b1; op = 3'b100; rs = 32'h1111_1111;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        chk("flush_start_hi", hi, 32'hAAAA_AAAA);

        // Reset mid-multiply
        start = 1'b1; op = 3'b000; rs = 32'd5; rt = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);

        run_op(3'b011, 32'd100, 32'd7, busy_cnt, done_cnt);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        chk("divu_done_pulses", done_cnt, 1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
